memwb_skid_reg: RTL and testbench

//  Parametrised MEM/WB pipeline stage with a valid/ready handshake and a 2-entry skid buffer.

---
 rtl/memwb_skid_reg.sv | 268 ++++++++++++++++++++++++++
 tb/tb_memwb_skid_reg.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/memwb_skid_reg.sv
// ----------------------------------------------------------------------------
// memwb_skid_reg
//
// MEM/WB pipeline stage built as a two-entry skid buffer. It sits between the
// data-memory stage and the register-file write port. An entry carries the
// RegWrite/MemToReg control bits, the destination register index, the ALU
// result and the load data. The stage produces the final writeback enable and
// writeback data, and it counts the cycles in which WB stalls it.
//
// Storage is a head register, which drives the *_out ports, and a skid
// register. The occupancy FSM (EMPTY/ONE/FULL) holds the valid bits of both:
//   head valid = state != EMPTY
//   skid valid = state == FULL
// The FSM state is also visible on the occupancy port.
//
// Handshake (valid/ready):
//   A transfer happens on a rising clock edge when valid and ready are both
//   high. The producer holds valid and the payload stable until that edge.
//   The consumer may drive ready at any time. On the input side,
//   in_ready = !skid_valid and is forced low during rst. It depends only on
//   registered state, so there is no combinational path from out_ready to
//   in_ready.
//
// Ports:
//   clk, rst            rising-edge clock; synchronous active-high reset
//   flush               drops every held entry and the same-cycle input
//   in_valid/in_ready   input handshake from the MEM stage
//   *_in                incoming entry fields
//   out_valid/out_ready output handshake towards WB
//   *_out               head entry fields (registered)
//   wb_en, wb_data      final register-file write enable and data
//   occupancy           number of held entries (0..2)
//   stall_cnt           saturating count of out_valid & !out_ready cycles
// ----------------------------------------------------------------------------
module memwb_skid_reg #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int ZERO_REG   = 1,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,

    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  RegWrite_in,
    input  logic                  MemToReg_in,
    input  logic [REG_ADDR_W-1:0] DestReg_in,
    input  logic [DATA_W-1:0]     ALU_result_in,
    input  logic [DATA_W-1:0]     MemRead_data_in,

    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  RegWrite_out,
    output logic                  MemToReg_out,
    output logic [REG_ADDR_W-1:0] DestReg_out,
    output logic [DATA_W-1:0]     ALU_result_out,
    output logic [DATA_W-1:0]     MemRead_data_out,

    output logic                  wb_en,
    output logic [DATA_W-1:0]     wb_data,
    output logic [1:0]            occupancy,
    output logic [CNT_W-1:0]      stall_cnt
);

    // ------------------------------------------------------------------
    // Occupancy state machine
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic head_valid;
    logic skid_valid;
    logic accept;
    logic consume;

    // Load strobes chosen by the next-state logic.
    logic head_from_in;
    logic head_from_skid;
    logic skid_from_in;

    // Head register
    logic                  head_rw_q,   head_rw_d;
    logic                  head_m2r_q,  head_m2r_d;
    logic [REG_ADDR_W-1:0] head_dest_q, head_dest_d;
    logic [DATA_W-1:0]     head_alu_q,  head_alu_d;
    logic [DATA_W-1:0]     head_mrd_q,  head_mrd_d;

    // Skid register
    logic                  skid_rw_q,   skid_rw_d;
    logic                  skid_m2r_q,  skid_m2r_d;
    logic [REG_ADDR_W-1:0] skid_dest_q, skid_dest_d;
    logic [DATA_W-1:0]     skid_alu_q,  skid_alu_d;
    logic [DATA_W-1:0]     skid_mrd_q,  skid_mrd_d;

    // Stall counter
    logic [CNT_W-1:0] stall_q, stall_d;

    logic dest_is_zero;

    assign head_valid = (state_q != ST_EMPTY);
    assign skid_valid = (state_q == ST_FULL);

    // Ready comes from registered state only. Holding it low during rst
    // stops a producer from seeing a transfer that reset then discards.
    assign in_ready = ~skid_valid & ~rst;

    assign accept  = in_valid & in_ready;
    assign consume = head_valid & out_ready;

    always_comb begin
        state_d        = state_q;
        head_from_in   = 1'b0;
        head_from_skid = 1'b0;
        skid_from_in   = 1'b0;

        unique case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    head_from_in = 1'b1;
                    state_d      = ST_ONE;
                end
            end
            ST_ONE: begin
                if (accept && consume) begin
                    // The head leaves and the new entry replaces it directly.
                    head_from_in = 1'b1;
                end else if (accept) begin
                    skid_from_in = 1'b1;
                    state_d      = ST_FULL;
                end else if (consume) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                // in_ready is low here, so only the drain path applies.
                if (consume) begin
                    head_from_skid = 1'b1;
                    state_d        = ST_ONE;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase

        // Flush drops everything, including the entry offered this cycle.
        // The payload registers keep stale values, but nothing marks them
        // valid.
        if (flush) begin
            state_d        = ST_EMPTY;
            head_from_in   = 1'b0;
            head_from_skid = 1'b0;
            skid_from_in   = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Payload next-state
    // ------------------------------------------------------------------
    always_comb begin
        head_rw_d   = head_rw_q;
        head_m2r_d  = head_m2r_q;
        head_dest_d = head_dest_q;
        head_alu_d  = head_alu_q;
        head_mrd_d  = head_mrd_q;

        if (head_from_in) begin
            head_rw_d   = RegWrite_in;
            head_m2r_d  = MemToReg_in;
            head_dest_d = DestReg_in;
            head_alu_d  = ALU_result_in;
            head_mrd_d  = MemRead_data_in;
        end else if (head_from_skid) begin
            head_rw_d   = skid_rw_q;
            head_m2r_d  = skid_m2r_q;
            head_dest_d = skid_dest_q;
            head_alu_d  = skid_alu_q;
            head_mrd_d  = skid_mrd_q;
        end
    end

    always_comb begin
        skid_rw_d   = skid_rw_q;
        skid_m2r_d  = skid_m2r_q;
        skid_dest_d = skid_dest_q;
        skid_alu_d  = skid_alu_q;
        skid_mrd_d  = skid_mrd_q;

        if (skid_from_in) begin
            skid_rw_d   = RegWrite_in;
            skid_m2r_d  = MemToReg_in;
            skid_dest_d = DestReg_in;
            skid_alu_d  = ALU_result_in;
            skid_mrd_d  = MemRead_data_in;
        end
    end

    // Counts every cycle in which WB holds off a valid head, flush cycles
    // included. Only rst clears the counter.
    always_comb begin
        stall_d = stall_q;
        if (head_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            head_rw_q   <= 1'b0;
            head_m2r_q  <= 1'b0;
            head_dest_q <= '0;
            head_alu_q  <= '0;
            head_mrd_q  <= '0;
            skid_rw_q   <= 1'b0;
            skid_m2r_q  <= 1'b0;
            skid_dest_q <= '0;
            skid_alu_q  <= '0;
            skid_mrd_q  <= '0;
            stall_q     <= '0;
        end else begin
            state_q     <= state_d;
            head_rw_q   <= head_rw_d;
            head_m2r_q  <= head_m2r_d;
            head_dest_q <= head_dest_d;
            head_alu_q  <= head_alu_d;
            head_mrd_q  <= head_mrd_d;
            skid_rw_q   <= skid_rw_d;
            skid_m2r_q  <= skid_m2r_d;
            skid_dest_q <= skid_dest_d;
            skid_alu_q  <= skid_alu_d;
            skid_mrd_q  <= skid_mrd_d;
            stall_q     <= stall_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign out_valid        = head_valid;
    assign RegWrite_out     = head_rw_q;
    assign MemToReg_out     = head_m2r_q;
    assign DestReg_out      = head_dest_q;
    assign ALU_result_out   = head_alu_q;
    assign MemRead_data_out = head_mrd_q;

    assign occupancy = 2'(state_q);
    assign stall_cnt = stall_q;

    // Register 0 is hardwired on RISC-style files, so a write to it is
    // dropped here when ZERO_REG is set.
    assign dest_is_zero = (ZERO_REG != 0) && (head_dest_q == '0);

    // A flushed head must never write, even if WB is ready this cycle.
    assign wb_en   = head_valid & out_ready & head_rw_q & ~dest_is_zero & ~flush;
    assign wb_data = head_m2r_q ? head_mrd_q : head_alu_q;

endmodule

// File: tb/tb_memwb_skid_reg.sv
module tb_memwb_skid_reg;

  localparam int DATA_W = 32;
  localparam int RA_W   = 5;
  localparam int ENT_W  = 2 + RA_W + 2 * DATA_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, flush, in_valid, out_ready;
  logic              rw_in, m2r_in;
  logic [RA_W-1:0]   dest_in;
  logic [DATA_W-1:0] alu_in, mrd_in;

  // dut1: ZERO_REG=1, CNT_W=4
  logic              in_ready1, out_valid1, rw_out1, m2r_out1, wb_en1;
  logic [RA_W-1:0]   dest_out1;
  logic [DATA_W-1:0] alu_out1, mrd_out1, wb_data1;
  logic [1:0]        occ1;
  logic [3:0]        stall1;

  // dut2: ZERO_REG=0, CNT_W=16
  logic              in_ready2, out_valid2, rw_out2, m2r_out2, wb_en2;
  logic [RA_W-1:0]   dest_out2;
  logic [DATA_W-1:0] alu_out2, mrd_out2, wb_data2;
  logic [1:0]        occ2;
  logic [15:0]       stall2;

  memwb_skid_reg #(.DATA_W(DATA_W), .REG_ADDR_W(RA_W), .ZERO_REG(1), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready1),
    .RegWrite_in(rw_in), .MemToReg_in(m2r_in), .DestReg_in(dest_in),
    .ALU_result_in(alu_in), .MemRead_data_in(mrd_in),
    .out_valid(out_valid1), .out_ready(out_ready),
    .RegWrite_out(rw_out1), .MemToReg_out(m2r_out1), .DestReg_out(dest_out1),
    .ALU_result_out(alu_out1), .MemRead_data_out(mrd_out1),
    .wb_en(wb_en1), .wb_data(wb_data1), .occupancy(occ1), .stall_cnt(stall1)
  );

  memwb_skid_reg #(.DATA_W(DATA_W), .REG_ADDR_W(RA_W), .ZERO_REG(0), .CNT_W(16)) dut_z0 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready2),
    .RegWrite_in(rw_in), .MemToReg_in(m2r_in), .DestReg_in(dest_in),
    .ALU_result_in(alu_in), .MemRead_data_in(mrd_in),
    .out_valid(out_valid2), .out_ready(out_ready),
    .RegWrite_out(rw_out2), .MemToReg_out(m2r_out2), .DestReg_out(dest_out2),
    .ALU_result_out(alu_out2), .MemRead_data_out(mrd_out2),
    .wb_en(wb_en2), .wb_data(wb_data2), .occupancy(occ2), .stall_cnt(stall2)
  );

  // ---------------- reference model / scoreboard ----------------
  // Entry layout: {RegWrite, MemToReg, Dest, ALU, Load}
  logic [ENT_W-1:0] exp_q[$];
  int unsigned exp_stall1, exp_stall2;
  bit          taken;       // offered entry left the source (accepted or flushed)
  bit          after_reset; // last edge applied rst
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Applies the rules of one clock edge to the queue model.
  task automatic model_update();
    bit rdy;
    taken = 1'b0;
    after_reset = 1'b0;
    if (rst) begin
      exp_q.delete();
      exp_stall1 = 0;
      exp_stall2 = 0;
      after_reset = 1'b1;
    end else begin
      if (exp_q.size() > 0 && !out_ready) begin
        if (exp_stall1 < 15) exp_stall1++;
        if (exp_stall2 < 65535) exp_stall2++;
      end
      if (flush) begin
        exp_q.delete();
        taken = in_valid;
      end else begin
        rdy = (exp_q.size() < 2);
        if (exp_q.size() > 0 && out_ready) void'(exp_q.pop_front());
        if (in_valid && rdy) begin
          exp_q.push_back({rw_in, m2r_in, dest_in, alu_in, mrd_in});
          taken = 1'b1;
        end
      end
    end
  endtask

  task automatic check_all();
    logic [ENT_W-1:0]  h;
    logic              v, e_rw, e_m2r;
    logic [RA_W-1:0]   e_dest;
    logic [DATA_W-1:0] e_alu, e_mrd, e_wbd;
    v      = (exp_q.size() > 0);
    h      = v ? exp_q[0] : '0;
    e_rw   = h[ENT_W-1];
    e_m2r  = h[ENT_W-2];
    e_dest = h[2*DATA_W +: RA_W];
    e_alu  = h[DATA_W +: DATA_W];
    e_mrd  = h[0 +: DATA_W];
    e_wbd  = e_m2r ? e_mrd : e_alu;

    chk("out_valid", out_valid1, v);
    chk("out_valid_z0", out_valid2, v);
    chk("in_ready", in_ready1, !rst && exp_q.size() < 2);
    chk("in_ready_z0", in_ready2, !rst && exp_q.size() < 2);
    chk("occupancy", occ1, exp_q.size());
    chk("occupancy_z0", occ2, exp_q.size());
    chk("stall_cnt", stall1, exp_stall1);
    chk("stall_cnt_z0", stall2, exp_stall2);
    if (v) begin
      chk("RegWrite_out", rw_out1, e_rw);
      chk("MemToReg_out", m2r_out1, e_m2r);
      chk("DestReg_out", dest_out1, e_dest);
      chk("ALU_result_out", alu_out1, e_alu);
      chk("MemRead_data_out", mrd_out1, e_mrd);
      chk("wb_data", wb_data1, e_wbd);
      chk("wb_data_z0", wb_data2, e_wbd);
    end
    if (after_reset) begin
      chk("rst_fields", {rw_out1, m2r_out1, dest_out1, alu_out1[15:0], mrd_out1[15:0]}, '0);
      chk("rst_alu", alu_out1, '0);
      chk("rst_mrd", mrd_out1, '0);
    end
    chk("wb_en", wb_en1, v && out_ready && !flush && e_rw && (e_dest != '0));
    chk("wb_en_z0", wb_en2, v && out_ready && !flush && e_rw);
  endtask

  // ---------------- driver tasks ----------------
  // One clock: model the edge, then compare at the falling edge.
  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_all();
  endtask

  task automatic set_in(input logic v, input logic rw, input logic m2r,
                        input logic [RA_W-1:0] d, input logic [DATA_W-1:0] a,
                        input logic [DATA_W-1:0] m);
    in_valid = v; rw_in = rw; m2r_in = m2r; dest_in = d; alu_in = a; mrd_in = m;
  endtask

  task automatic rand_entry();
    set_in(($urandom_range(0, 9) < 7), 1'(($urandom_range(0, 3) != 0)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) == 0) ? '0 : RA_W'($urandom_range(0, 31)),
           $urandom, $urandom);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [DATA_W-1:0] alu_vals [4];
    alu_vals[0] = 32'h11; alu_vals[1] = 32'h22; alu_vals[2] = 32'h33; alu_vals[3] = 32'h44;

    // T1 reset with in_valid held high
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    set_in(1'b1, 1'b1, 1'b0, 5'd7, 32'h1234, 32'h5678);
    step();
    step();
    chk("t1_out_valid", out_valid1, 1'b0);
    chk("t1_in_ready", in_ready1, 1'b0);
    chk("t1_occupancy", occ1, 2'd0);
    chk("t1_stall_cnt", stall1, 4'd0);
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("t1_in_ready_after", in_ready1, 1'b1);

    // T2 streaming, out_ready high
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, 1'b1, 1'b0, RA_W'(i + 1), alu_vals[i], $urandom);
      step();
      chk("t2_alu", alu_out1, alu_vals[i]);
      chk("t2_wb_data", wb_data1, alu_vals[i]);
      chk("t2_occupancy", occ1, 2'd1);
    end
    in_valid = 1'b0;
    step();

    // T3 backpressure: A, B fill the stage, C waits
    out_ready = 1'b0;
    set_in(1'b1, 1'b1, 1'b0, 5'd3, 32'hA, 32'h0);
    step();
    set_in(1'b1, 1'b1, 1'b0, 5'd4, 32'hB, 32'h0);
    step();
    chk("t3_occupancy_full", occ1, 2'd2);
    chk("t3_in_ready_full", in_ready1, 1'b0);
    set_in(1'b1, 1'b1, 1'b0, 5'd5, 32'hC, 32'h0);
    step();
    step();
    chk("t3_head_still_a", dest_out1, 5'd3);
    out_ready = 1'b1;
    step();
    chk("t3_head_b", dest_out1, 5'd4);
    step();
    chk("t3_head_c", dest_out1, 5'd5);
    in_valid = 1'b0;
    step();
    chk("t3_drained", occ1, 2'd0);

    // T4 writeback mux and register-0 suppression
    out_ready = 1'b1;
    set_in(1'b1, 1'b1, 1'b1, 5'd0, 32'h5, 32'hDEADBEEF);
    step();
    in_valid = 1'b0;
    #1;
    chk("t4_wb_data", wb_data1, 32'hDEADBEEF);
    chk("t4_wb_en_zero_reg1", wb_en1, 1'b0);
    chk("t4_wb_en_zero_reg0", wb_en2, 1'b1);
    step();

    // T5 flush while full, with an input offered in the same cycle
    out_ready = 1'b0;
    set_in(1'b1, 1'b1, 1'b0, 5'd9, 32'h99, 32'h0);
    step();
    set_in(1'b1, 1'b1, 1'b0, 5'd10, 32'hAA, 32'h0);
    step();
    set_in(1'b1, 1'b1, 1'b0, 5'd11, 32'hBB, 32'h0);
    flush = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("t5_wb_en_flush_cycle", wb_en1, 1'b0);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("t5_occupancy", occ1, 2'd0);
    chk("t5_out_valid", out_valid1, 1'b0);
    chk("t5_wb_en", wb_en1, 1'b0);
    step();
    step();

    // T6 stall saturation, then reset clears the counter
    out_ready = 1'b0;
    set_in(1'b1, 1'b1, 1'b0, 5'd12, 32'hCC, 32'h0);
    step();
    in_valid = 1'b0;
    repeat (20) step();
    chk("t6_stall_sat", stall1, 4'd15);
    step();
    chk("t6_stall_hold", stall1, 4'd15);
    rst = 1'b1;
    step();
    chk("t6_stall_rst", stall1, 4'd0);
    rst = 1'b0;

    // Randomized traffic against the queue model
    rand_entry();
    for (int n = 0; n < 400; n++) begin
      flush     = ($urandom_range(0, 29) == 0);
      rst       = ($urandom_range(0, 149) == 0);
      out_ready = ($urandom_range(0, 9) < 6);
      step();
      if (!in_valid || taken || after_reset) rand_entry();
    end
    flush = 1'b0;
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
